// File: rtl/exec_sequencer.sv
// exec_sequencer
//   Multi-cycle control sequencer for the execution units. Each instruction
//   goes through FETCH -> DECODE -> READ -> EXEC. One unit is enabled
//   (active low) for READ and EXEC. The register-file write is strobed in
//   EXEC, and the PC and retired count advance at the end of EXEC. An
//   unsupported opcode parks the sequencer in HALT until reset.
//
// Parameters
//   XLEN      data/address width
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   mem_addr/mem_req    fetch address and request, driven during FETCH
//   mem_ready/mem_rdata fetch handshake and instruction word
//   instruction         latched instruction register, fanned out to units
//   alu_imm_enable_n    active-low enable, OP-IMM unit
//   alu_reg_enable_n    active-low enable, OP unit
//   reg_write_en        one-cycle register-file write strobe (EXEC)
//   pc, instret         program counter, retired-instruction counter
//   halted, illegal     sequencer stopped / stop caused by bad opcode
module exec_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_req,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic            alu_imm_enable_n,
  output logic            alu_reg_enable_n,
  output logic            reg_write_en,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instret,
  output logic            halted,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    READ,
    EXEC,
    HALT
  } state_t;

  state_t state;
  state_t next_state;

  // Unit selection captured in DECODE so READ/EXEC never re-decode the IR.
  logic sel_imm;
  logic sel_reg;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic       is_op_imm;
  logic       is_op;

  assign opcode    = instruction[6:0];
  assign rd        = instruction[11:7];
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_op     = (opcode == OPC_OP);

  assign mem_addr = pc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next state and state-decoded control outputs
  always_comb begin
    next_state       = state;
    mem_req          = 1'b0;
    alu_imm_enable_n = 1'b1;
    alu_reg_enable_n = 1'b1;
    reg_write_en     = 1'b0;
    halted           = 1'b0;

    unique case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          next_state = DECODE;
        end
      end
      DECODE: begin
        next_state = (is_op_imm || is_op) ? READ : HALT;
      end
      READ: begin
        alu_imm_enable_n = ~sel_imm;
        alu_reg_enable_n = ~sel_reg;
        next_state       = EXEC;
      end
      EXEC: begin
        alu_imm_enable_n = ~sel_imm;
        alu_reg_enable_n = ~sel_reg;
        reg_write_en     = (rd != 5'd0);
        next_state       = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        next_state = FETCH;
      end
    endcase

    // Reset forces the control outputs idle in the same cycle it is
    // asserted. This covers a reset that lands in EXEC: it drops the write
    // strobe before the edge instead of after it.
    if (rst) begin
      mem_req          = 1'b0;
      alu_imm_enable_n = 1'b1;
      alu_reg_enable_n = 1'b1;
      reg_write_en     = 1'b0;
      halted           = 1'b0;
    end
  end

  // Datapath registers: IR, unit selection, PC, retired count, illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instruction <= '0;
      instret     <= '0;
      illegal     <= 1'b0;
      sel_imm     <= 1'b0;
      sel_reg     <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (mem_ready) begin
            instruction <= mem_rdata;
          end
        end
        DECODE: begin
          sel_imm <= is_op_imm;
          sel_reg <= is_op;
          if (!(is_op_imm || is_op)) begin
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          pc      <= pc + XLEN'(4);
          instret <= instret + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: RESET_PC = 0x100 (main sequence)
  logic        rst0 = 1'b1;
  logic        rdy0 = 1'b0;
  logic [31:0] rdata0 = '0;
  logic [31:0] addr0, ir0, pc0, ret0;
  logic        req0, imm_n0, reg_n0, we0, halted0, ill0;

  // DUT 1: RESET_PC = 0xFFFF_FFFC (PC wrap)
  logic        rst1 = 1'b1;
  logic        rdy1 = 1'b0;
  logic [31:0] rdata1 = '0;
  logic [31:0] addr1, ir1, pc1, ret1;
  logic        req1, imm_n1, reg_n1, we1, halted1, ill1;

  exec_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut0 (
    .clk(clk), .rst(rst0), .mem_addr(addr0), .mem_req(req0),
    .mem_ready(rdy0), .mem_rdata(rdata0), .instruction(ir0),
    .alu_imm_enable_n(imm_n0), .alu_reg_enable_n(reg_n0),
    .reg_write_en(we0), .pc(pc0), .instret(ret0),
    .halted(halted0), .illegal(ill0)
  );

  exec_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst1), .mem_addr(addr1), .mem_req(req1),
    .mem_ready(rdy1), .mem_rdata(rdata1), .instruction(ir1),
    .alu_imm_enable_n(imm_n1), .alu_reg_enable_n(reg_n1),
    .reg_write_en(we1), .pc(pc1), .instret(ret1),
    .halted(halted1), .illegal(ill1)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        imm_n;
    logic        reg_n;
    logic        we;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] ret;
    logic        halted;
    logic        ill;
  } vec_t;

  localparam int NVEC = 25;
  vec_t tbl [NVEC];

  int n_checks = 0;
  int n_errors = 0;

  function automatic vec_t mk(
    logic rst, logic rdy, logic [31:0] rdata,
    logic req, logic [31:0] addr, logic imm_n, logic reg_n, logic we,
    logic [31:0] pc, logic [31:0] ir, logic [31:0] ret,
    logic halted, logic ill);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rdata = rdata;
    v.req = req; v.addr = addr; v.imm_n = imm_n; v.reg_n = reg_n; v.we = we;
    v.pc = pc; v.ir = ir; v.ret = ret; v.halted = halted; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_dut0(input int idx, input vec_t v);
    chk("mem_req",      idx, {31'd0, req0},    {31'd0, v.req});
    chk("mem_addr",     idx, addr0,            v.addr);
    chk("imm_enable_n", idx, {31'd0, imm_n0},  {31'd0, v.imm_n});
    chk("reg_enable_n", idx, {31'd0, reg_n0},  {31'd0, v.reg_n});
    chk("reg_write_en", idx, {31'd0, we0},     {31'd0, v.we});
    chk("pc",           idx, pc0,              v.pc);
    chk("instruction",  idx, ir0,              v.ir);
    chk("instret",      idx, ret0,             v.ret);
    chk("halted",       idx, {31'd0, halted0}, {31'd0, v.halted});
    chk("illegal",      idx, {31'd0, ill0},    {31'd0, v.ill});
  endtask

  // Drive one cycle on DUT 0: inputs at negedge, outputs sampled 1 ns later.
  task automatic step0(input int idx, input vec_t v);
    @(negedge clk);
    rst0   = v.rst;
    rdy0   = v.rdy;
    rdata0 = v.rdata;
    #1;
    check_dut0(idx, v);
  endtask

  initial begin
    vec_t h;

    // Columns: rst rdy rdata | req addr imm_n reg_n we | pc ir instret | halted illegal
    // Reset held (plus one reset edge before the table)
    tbl[0]  = mk(1,0,32'h0,        0,32'h100,1,1,0, 32'h100,32'h0,0, 0,0);
    tbl[1]  = mk(1,0,32'h0,        0,32'h100,1,1,0, 32'h100,32'h0,0, 0,0);
    // addi x1,x0,5 zero-wait: FETCH DECODE READ EXEC
    tbl[2]  = mk(0,1,32'h00500093, 1,32'h100,1,1,0, 32'h100,32'h0,0, 0,0);
    tbl[3]  = mk(0,0,32'h0,        0,32'h100,1,1,0, 32'h100,32'h00500093,0, 0,0);
    tbl[4]  = mk(0,0,32'h0,        0,32'h100,0,1,0, 32'h100,32'h00500093,0, 0,0);
    tbl[5]  = mk(0,0,32'h0,        0,32'h100,0,1,1, 32'h100,32'h00500093,0, 0,0);
    // add x3,x1,x2 with 3 wait cycles, 7 cycles total
    tbl[6]  = mk(0,0,32'h002081B3, 1,32'h104,1,1,0, 32'h104,32'h00500093,1, 0,0);
    tbl[7]  = mk(0,0,32'h002081B3, 1,32'h104,1,1,0, 32'h104,32'h00500093,1, 0,0);
    tbl[8]  = mk(0,0,32'h002081B3, 1,32'h104,1,1,0, 32'h104,32'h00500093,1, 0,0);
    tbl[9]  = mk(0,1,32'h002081B3, 1,32'h104,1,1,0, 32'h104,32'h00500093,1, 0,0);
    // mem_ready outside FETCH must not touch IR
    tbl[10] = mk(0,1,32'hDEADBEEF, 0,32'h104,1,1,0, 32'h104,32'h002081B3,1, 0,0);
    tbl[11] = mk(0,1,32'hDEADBEEF, 0,32'h104,1,0,0, 32'h104,32'h002081B3,1, 0,0);
    tbl[12] = mk(0,1,32'hDEADBEEF, 0,32'h104,1,0,1, 32'h104,32'h002081B3,1, 0,0);
    // nop (rd = x0): no write strobe
    tbl[13] = mk(0,1,32'h00000013, 1,32'h108,1,1,0, 32'h108,32'h002081B3,2, 0,0);
    tbl[14] = mk(0,0,32'h0,        0,32'h108,1,1,0, 32'h108,32'h00000013,2, 0,0);
    tbl[15] = mk(0,0,32'h0,        0,32'h108,0,1,0, 32'h108,32'h00000013,2, 0,0);
    tbl[16] = mk(0,0,32'h0,        0,32'h108,0,1,0, 32'h108,32'h00000013,2, 0,0);
    // addi with reset asserted in EXEC: abandoned
    tbl[17] = mk(0,1,32'h00500093, 1,32'h10C,1,1,0, 32'h10C,32'h00000013,3, 0,0);
    tbl[18] = mk(0,0,32'h0,        0,32'h10C,1,1,0, 32'h10C,32'h00500093,3, 0,0);
    tbl[19] = mk(0,0,32'h0,        0,32'h10C,0,1,0, 32'h10C,32'h00500093,3, 0,0);
    tbl[20] = mk(1,0,32'h0,        0,32'h10C,1,1,0, 32'h10C,32'h00500093,3, 0,0);
    tbl[21] = mk(0,0,32'h0,        1,32'h100,1,1,0, 32'h100,32'h0,0, 0,0);
    // Illegal opcode -> HALT
    tbl[22] = mk(0,1,32'hFFFFFFFF, 1,32'h100,1,1,0, 32'h100,32'h0,0, 0,0);
    tbl[23] = mk(0,1,32'h00500093, 0,32'h100,1,1,0, 32'h100,32'hFFFFFFFF,0, 0,0);
    tbl[24] = mk(0,1,32'h00500093, 0,32'h100,1,1,0, 32'h100,32'hFFFFFFFF,0, 1,1);

    // One reset edge so registered outputs are defined before the table.
    @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      step0(i, tbl[i]);
    end

    // HALT is terminal: 20 more cycles with memory toggling ready.
    for (int i = 0; i < 20; i++) begin
      h = mk(0, (i % 2 == 0), 32'h00500093,
             0,32'h100,1,1,0, 32'h100,32'hFFFFFFFF,0, 1,1);
      step0(100 + i, h);
    end

    // Reset recovers from HALT to FETCH at RESET_PC.
    h = mk(1,0,32'h0, 0,32'h100,1,1,0, 32'h100,32'hFFFFFFFF,0, 0,1);
    step0(200, h);
    h = mk(0,0,32'h0, 1,32'h100,1,1,0, 32'h100,32'h0,0, 0,0);
    step0(201, h);

    // PC wrap on DUT 1: addi from 0xFFFF_FFFC, zero-wait memory.
    @(negedge clk);
    rst1 = 1'b0; rdy1 = 1'b1; rdata1 = 32'h00500093;
    #1;
    chk("wrap_pc_start",  0, pc1,  32'hFFFF_FFFC);
    chk("wrap_addr",      0, addr1, 32'hFFFF_FFFC);
    chk("wrap_mem_req",   0, {31'd0, req1}, 32'd1);
    @(negedge clk);
    rdy1 = 1'b0;
    #1;
    chk("wrap_ir",        1, ir1, 32'h00500093);
    @(negedge clk);
    #1;
    chk("wrap_imm_en_n",  2, {31'd0, imm_n1}, 32'd0);
    @(negedge clk);
    #1;
    chk("wrap_write_en",  3, {31'd0, we1}, 32'd1);
    chk("wrap_pc_exec",   3, pc1, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    chk("wrap_pc",        4, pc1, 32'h0000_0000);
    chk("wrap_addr",      4, addr1, 32'h0000_0000);
    chk("wrap_instret",   4, ret1, 32'd1);
    chk("wrap_mem_req",   4, {31'd0, req1}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Enables are never both low on either DUT.
  always @(negedge clk) begin
    if (!imm_n0 && !reg_n0) begin
      n_errors++;
      $display("FAIL both_enables dut0: imm_n=%b reg_n=%b required not both 0", imm_n0, reg_n0);
    end
    if (!imm_n1 && !reg_n1) begin
      n_errors++;
      $display("FAIL both_enables dut1: imm_n=%b reg_n=%b required not both 0", imm_n1, reg_n1);
    end
  end

  // Hard time limit in case the sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
